// File: rtl/port_pkg.sv
// Shared definitions for the lane-select display block: lane width,
// operating-mode encoding and a ceiling-log2 helper for sizing indices.
package port_pkg;

    localparam int LANE_W = 8;

    // Operating mode decoded each cycle from scan_en and its history.
    typedef enum logic [1:0] {
        MODE_MANUAL     = 2'd0,
        MODE_SCAN_START = 2'd1,
        MODE_SCAN_RUN   = 2'd2
    } mode_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Auto-scan period divider: counts 0..SCAN_DIV-1 while enabled and pulses
// tick on the last count. Disabling it parks the counter at 0 so that the
// next enable always starts a full period.
module scan_tick
    import port_pkg::*;
#(
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // Period counter: wraps at LAST, held at zero whenever scanning is paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= {CNT_W{1'b0}};
        end else if (!en) begin
            div_cnt <= {CNT_W{1'b0}};
        end else if (div_cnt == LAST) begin
            div_cnt <= {CNT_W{1'b0}};
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Tick is combinational so the lane advance lands on the same edge as the wrap.
    assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/port_lane_sel.sv
// Lane selector for a byte-wide display port. A wide receive word is
// snapshotted on load; one 8-bit lane of it is shown on port_out, chosen
// either by the sel switches or by a free-running auto-scan.
module port_lane_sel
    import port_pkg::*;
#(
    parameter  int NUM_LANES = 8,
    parameter  int SCAN_DIV  = 50_000_000,
    localparam int SEL_W     = clog2(NUM_LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES*LANE_W-1:0] data_in,
    input  logic                        load,
    input  logic [SEL_W-1:0]            sel,
    input  logic                        scan_en,
    output logic [LANE_W-1:0]           port_out,
    output logic [SEL_W-1:0]            lane_idx,
    output logic                        loaded
);

    localparam logic [SEL_W:0]   LANE_CNT = NUM_LANES[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_LANES - 1);

    logic [NUM_LANES*LANE_W-1:0] snap;
    logic [NUM_LANES*LANE_W-1:0] src;
    logic                        scan_en_q;
    logic                        rst_q;
    logic [SEL_W-1:0]            scan_idx;
    logic [SEL_W-1:0]            start_idx;
    logic [SEL_W-1:0]            next_scan_idx;
    logic [SEL_W-1:0]            cur_idx;
    logic [LANE_W-1:0]           lane_byte;
    logic                        tick;
    logic                        scan_run;
    mode_e                       mode;

    // Mode decode. The cycle right after reset is treated as a running scan
    // (not an entry) so a scan held through reset resumes from lane 0.
    always_comb begin
        mode = MODE_MANUAL;
        if (!scan_en) begin
            mode = MODE_MANUAL;
        end else if (!scan_en_q && !rst_q) begin
            mode = MODE_SCAN_START;
        end else begin
            mode = MODE_SCAN_RUN;
        end
    end

    assign scan_run = (mode == MODE_SCAN_RUN);

    scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_run),
        .tick (tick)
    );

    // Lane index selection: switches, clamped scan start, or scan position.
    always_comb begin
        start_idx     = {SEL_W{1'b0}};
        next_scan_idx = {SEL_W{1'b0}};
        cur_idx       = sel;
        if ({1'b0, sel} < LANE_CNT) begin
            start_idx = sel;
        end else begin
            start_idx = {SEL_W{1'b0}};
        end
        if (scan_idx == LAST_IDX) begin
            next_scan_idx = {SEL_W{1'b0}};
        end else begin
            next_scan_idx = scan_idx + SEL_W'(1);
        end
        case (mode)
            MODE_MANUAL:     cur_idx = sel;
            MODE_SCAN_START: cur_idx = start_idx;
            MODE_SCAN_RUN:   cur_idx = tick ? next_scan_idx : scan_idx;
            default:         cur_idx = sel;
        endcase
    end

    // Lane mux with load bypass; indices past the last lane read as zero.
    always_comb begin
        src       = load ? data_in : snap;
        lane_byte = {LANE_W{1'b0}};
        if ({1'b0, cur_idx} < LANE_CNT) begin
            lane_byte = src[int'(cur_idx) * LANE_W +: LANE_W];
        end else begin
            lane_byte = {LANE_W{1'b0}};
        end
    end

    // Snapshot of the receive word and the sticky loaded flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap   <= {(NUM_LANES*LANE_W){1'b0}};
            loaded <= 1'b0;
        end else if (load) begin
            snap   <= data_in;
            loaded <= 1'b1;
        end
    end

    // History of scan_en and rst for entry detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_en_q <= 1'b0;
            rst_q     <= 1'b1;
        end else begin
            scan_en_q <= scan_en;
            rst_q     <= 1'b0;
        end
    end

    // Scan position: seeded on scan entry, advanced on each divider tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx <= {SEL_W{1'b0}};
        end else begin
            case (mode)
                MODE_SCAN_START: scan_idx <= start_idx;
                MODE_SCAN_RUN:   scan_idx <= tick ? next_scan_idx : scan_idx;
                default:         scan_idx <= scan_idx;
            endcase
        end
    end

    // Displayed byte and its lane index, always registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_out <= {LANE_W{1'b0}};
            lane_idx <= {SEL_W{1'b0}};
        end else begin
            port_out <= lane_byte;
            lane_idx <= cur_idx;
        end
    end

endmodule

// File: tb/tb_port_lane_sel.sv
// Directed bench for port_lane_sel: an 8-lane instance driven from a vector
// table plus hand-written multi-cycle sequences, and a 6-lane instance for
// out-of-range selects.
module tb_port_lane_sel;

    localparam logic [63:0] D = 64'h03003216_0804FF02;
    localparam logic [63:0] J = 64'hDEADBEEF_CAFEBABE;

    logic        clk = 1'b0;
    logic        rst, load, scan_en;
    logic [63:0] data_in;
    logic [2:0]  sel;
    logic [7:0]  port_out;
    logic [2:0]  lane_idx;
    logic        loaded;

    logic        rst6, load6, scan_en6;
    logic [47:0] data_in6;
    logic [2:0]  sel6;
    logic [7:0]  port_out6;
    logic [2:0]  lane_idx6;
    logic        loaded6;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        rst;
        logic        load;
        logic [63:0] data;
        logic [2:0]  sel;
        logic        scan_en;
        logic [7:0]  exp_port;
        logic [2:0]  exp_idx;
        logic        exp_loaded;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    port_lane_sel #(.NUM_LANES(8), .SCAN_DIV(4)) u_dut8 (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .sel(sel),
        .scan_en(scan_en), .port_out(port_out), .lane_idx(lane_idx), .loaded(loaded)
    );

    port_lane_sel #(.NUM_LANES(6), .SCAN_DIV(4)) u_dut6 (
        .clk(clk), .rst(rst6), .data_in(data_in6), .load(load6), .sel(sel6),
        .scan_en(scan_en6), .port_out(port_out6), .lane_idx(lane_idx6), .loaded(loaded6)
    );

    task automatic check(input string nm, input logic [7:0] ap, input logic [2:0] ai,
                         input logic al, input logic [7:0] ep, input logic [2:0] ei,
                         input logic el);
        vectors++;
        if (ap !== ep) begin
            miscompares++;
            $display("FAIL %s port_out: got %h want %h", nm, ap, ep);
        end
        if (ai !== ei) begin
            miscompares++;
            $display("FAIL %s lane_idx: got %0d want %0d", nm, ai, ei);
        end
        if (al !== el) begin
            miscompares++;
            $display("FAIL %s loaded: got %b want %b", nm, al, el);
        end
    endtask

    task automatic apply(input string nm, input logic r, input logic ld, input logic [63:0] d,
                         input logic [2:0] s, input logic se, input logic [7:0] ep,
                         input logic [2:0] ei, input logic el);
        rst = r; load = ld; data_in = d; sel = s; scan_en = se;
        @(posedge clk); #1;
        check(nm, port_out, lane_idx, loaded, ep, ei, el);
    endtask

    task automatic apply6(input string nm, input logic r, input logic ld, input logic [47:0] d,
                          input logic [2:0] s, input logic se, input logic [7:0] ep,
                          input logic [2:0] ei, input logic el);
        rst6 = r; load6 = ld; data_in6 = d; sel6 = s; scan_en6 = se;
        @(posedge clk); #1;
        check(nm, port_out6, lane_idx6, loaded6, ep, ei, el);
    endtask

    task automatic add(input logic r, input logic ld, input logic [63:0] d, input logic [2:0] s,
                       input logic se, input logic [7:0] ep, input logic [2:0] ei, input logic el);
        vec_t v;
        v.rst = r; v.load = ld; v.data = d; v.sel = s; v.scan_en = se;
        v.exp_port = ep; v.exp_idx = ei; v.exp_loaded = el;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = 64'h0; sel = 3'd0; scan_en = 1'b0;
        rst6 = 1'b1; load6 = 1'b0; data_in6 = 48'h0; sel6 = 3'd0; scan_en6 = 1'b0;

        // Reset, reset-over-load, manual select, hold, sel change from snapshot.
        add(1'b1, 1'b0, 64'h0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b1, 1'b1, D,     3'd1, 1'b0, 8'h00, 3'd0, 1'b0);
        add(1'b0, 1'b1, D,     3'd1, 1'b0, 8'hFF, 3'd1, 1'b1);
        add(1'b0, 1'b0, J,     3'd1, 1'b0, 8'hFF, 3'd1, 1'b1);
        add(1'b0, 1'b0, J,     3'd5, 1'b0, 8'h32, 3'd5, 1'b1);
        add(1'b0, 1'b0, J,     3'd7, 1'b0, 8'h03, 3'd7, 1'b1);
        add(1'b0, 1'b0, J,     3'd0, 1'b0, 8'h02, 3'd0, 1'b1);
        // Auto-scan from lane 6: 6,7,0,1 each for 4 cycles; sel ignored once running.
        add(1'b0, 1'b0, J,     3'd6, 1'b1, 8'h00, 3'd6, 1'b1);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, J, 3'd6, 1'b1, 8'h00, 3'd6, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, J, 3'd2, 1'b1, 8'h03, 3'd7, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, J, 3'd2, 1'b1, 8'h02, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, J, 3'd2, 1'b1, 8'hFF, 3'd1, 1'b1);
        // Leave scan: back to sel lane next cycle; re-enter with a fresh period.
        add(1'b0, 1'b0, J,     3'd2, 1'b0, 8'h04, 3'd2, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b0, J, 3'd2, 1'b1, 8'h04, 3'd2, 1'b1);
        add(1'b0, 1'b0, J,     3'd2, 1'b1, 8'h08, 3'd3, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].load, tbl[i].data, tbl[i].sel,
                  tbl[i].scan_en, tbl[i].exp_port, tbl[i].exp_idx, tbl[i].exp_loaded);
        end

        // Load coinciding with the tick into lane 0 shows the new data immediately.
        apply("lt_exit", 1'b0, 1'b0, J, 3'd7, 1'b0, 8'h03, 3'd7, 1'b1);
        for (int i = 0; i < 4; i++) apply($sformatf("lt_l7_%0d", i), 1'b0, 1'b0, J, 3'd7, 1'b1, 8'h03, 3'd7, 1'b1);
        apply("lt_tick", 1'b0, 1'b1, 64'h7E, 3'd7, 1'b1, 8'h7E, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) apply($sformatf("lt_l0_%0d", i), 1'b0, 1'b0, J, 3'd7, 1'b1, 8'h7E, 3'd0, 1'b1);
        apply("lt_l1", 1'b0, 1'b0, J, 3'd7, 1'b1, 8'h00, 3'd1, 1'b1);

        // Mid-scan reset during lane 3, then resume from lane 0 with a full period.
        apply("mr_load", 1'b0, 1'b1, D, 3'd6, 1'b1, 8'hFF, 3'd1, 1'b1);
        for (int i = 0; i < 2; i++) apply($sformatf("mr_l1_%0d", i), 1'b0, 1'b0, J, 3'd6, 1'b1, 8'hFF, 3'd1, 1'b1);
        for (int i = 0; i < 4; i++) apply($sformatf("mr_l2_%0d", i), 1'b0, 1'b0, J, 3'd6, 1'b1, 8'h04, 3'd2, 1'b1);
        for (int i = 0; i < 2; i++) apply($sformatf("mr_l3_%0d", i), 1'b0, 1'b0, J, 3'd6, 1'b1, 8'h08, 3'd3, 1'b1);
        apply("mr_rst", 1'b1, 1'b0, J, 3'd6, 1'b1, 8'h00, 3'd0, 1'b0);
        apply("mr_r0_load", 1'b0, 1'b1, D, 3'd6, 1'b1, 8'h02, 3'd0, 1'b1);
        for (int i = 0; i < 2; i++) apply($sformatf("mr_r0_%0d", i), 1'b0, 1'b0, J, 3'd6, 1'b1, 8'h02, 3'd0, 1'b1);
        apply("mr_r1", 1'b0, 1'b0, J, 3'd6, 1'b1, 8'hFF, 3'd1, 1'b1);

        // Six-lane instance: out-of-range selects read zero; scan entry clamps to 0.
        apply6("n6_rst", 1'b1, 1'b0, 48'h0, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0);
        apply6("n6_sel5", 1'b0, 1'b1, D[47:0], 3'd5, 1'b0, 8'h32, 3'd5, 1'b1);
        apply6("n6_sel7", 1'b0, 1'b0, 48'h0, 3'd7, 1'b0, 8'h00, 3'd7, 1'b1);
        apply6("n6_sel6", 1'b0, 1'b0, 48'h0, 3'd6, 1'b0, 8'h00, 3'd6, 1'b1);
        apply6("n6_clamp", 1'b0, 1'b0, 48'h0, 3'd7, 1'b1, 8'h02, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
